mole_spawner: RTL and testbench
===============================

# mole_spawner

Upstream stage of the whac-a-mole game FSM. Each time the FSM raises `ready_for_mole`, this block draws a fresh pseudo-random mole position from a free-running LFSR and drives it as a one-hot `led_number`. It then pulses `rng_ready` for one cycle. The hard level (`level_select == 3'b100`) lights two distinct moles at once. Positions never repeat the previous mole, and the draw latency is bounded.

## Interface
- `LED_COUNT`, 18: number of mole LEDs/switches; `led_number` width.
- `LFSR_SEED`, 16'hACE1: LFSR load value on reset; a value of 0 is replaced by 16'h0001.
- `MAX_TRIES`, 8: rejected candidates allowed per mole before the fallback position is used.
- `clk` in 1: system clock.
- `reset` in 1: synchronous, active-high reset.
- `ready_for_mole` in 1: FSM request for a new mole (level, held while FSM is in Choose_Mole).
- `level_select` in 3: level code from FSM; `3'b100` selects two-mole mode, any other value selects one mole.
- `led_number` out LED_COUNT: one-hot (or two-hot) mole mask, held until the next completed draw.
- `rng_ready` out 1: single-cycle pulse; `led_number` is valid in the same cycle.
- `mole_index` out 5: index of the first mole in the current mask.
- `busy` out 1: high while in DRAW1/DRAW2.

## Operation
- **LFSR.** 16-bit Galois, polynomial x^16+x^14+x^13+x^11+1 (mask 16'hB400). Advances every cycle in all states, never stalls, and is never zero.
- **Candidate.** `cand = lfsr[4:0]`, evaluated in the current cycle.
- **Stored state.** `prev_index` (5 bits) holds the first mole of the last completed draw. Reset value 5'd31 means "none".
- **IDLE.** If `ready_for_mole` is high, latch `level_select` into `lvl_q`, clear `tries`, go to DRAW1.
- **DRAW1.**
  - If `tries == MAX_TRIES`, accept the fallback `(prev_index+1) mod LED_COUNT`, or 0 if prev is none.
  - Otherwise accept `cand` when `cand < LED_COUNT` and `cand != prev_index`; on reject, increment `tries` and stay.
  - On accept: store `first`. If `lvl_q == 3'b100`, clear `tries` and go to DRAW2; otherwise go to DONE.
- **DRAW2.**
  - Same rule as DRAW1, except the exclusion is `first`, not `prev_index`.
  - The fallback is `(first+1) mod LED_COUNT`.
  - On accept, go to DONE.
- **DONE transition.** On the accepting edge:
  - `led_number` <= one-hot(first) OR one-hot(second if two-mole).
  - `mole_index` <= first; `prev_index` <= first; `rng_ready` <= 1.
  - Next state is WAIT_DROP.
- **WAIT_DROP.** `rng_ready` returns to 0 after one cycle. Stay until `ready_for_mole == 0`, then go to IDLE. This guarantees one draw per request.
- **Abort.** If `ready_for_mole` falls while in DRAW1/DRAW2, go to IDLE. No output changes and `prev_index` is untouched.
- **Level changes.** A `level_select` change mid-draw has no effect, because `lvl_q` is used.
- **Two-mole fallback.** The DRAW2 fallback may equal `prev_index`; this is allowed. Only first ≠ prev and second ≠ first are guaranteed.

## Timing
- Reset values: `led_number` = 0, `rng_ready` = 0, `mole_index` = 0, `busy` = 0, state IDLE, `prev_index` = 31, LFSR = seed.
- Reset mid-draw returns everything to the reset values on the next edge.
- One-mole latency: `ready_for_mole` sampled high in IDLE at cycle N → DRAW1 at N+1 → `rng_ready` high at N+2 at best. Worst case is N+2+MAX_TRIES.
- Two-mole latency: best N+3, worst N+3+2·MAX_TRIES.
- `rng_ready` is exactly one cycle wide and never high in two consecutive cycles.
- `led_number` changes only in the cycle `rng_ready` rises.
- `busy` is combinational from state.

## Test plan
- **Reset.** Assert `reset` for 2 cycles → all outputs 0. A first request with level 3'b001 yields `rng_ready` at N+2..N+10, popcount(`led_number`) = 1, and bit `mole_index` set.
- **Fallback, no history.** With `MAX_TRIES` = 0 and prev none, a request gives `led_number` = 18'h00001 and `mole_index` = 0 at N+2. The next request gives 18'h00002; after index 17 the next is index 0.
- **Random sequence.** 1000 back-to-back requests emulating FSM handshakes (drop `ready_for_mole` on `rng_ready`) → no two consecutive `mole_index` equal, all < 18, every index hit at least once, and each latency ≤ 2+MAX_TRIES.
- **Two-mole mode.** `level_select` = 3'b100 → popcount(`led_number`) = 2, two distinct bits, `mole_index` ≠ previous, latency ≤ 3+16. Changing level to 3'b001 mid-draw still yields 2 bits.
- **Abort.** Drop `ready_for_mole` while `busy` → no `rng_ready`, `led_number` unchanged, IDLE next cycle.
- **Reset mid-draw.** Assert `reset` in DRAW2 → outputs 0 next cycle and `prev_index` back to none.

Source files
------------

// File: rtl/mole_spawner.sv
// mole_spawner: draws pseudo-random, non-repeating mole positions for the
// whac-a-mole FSM, one or two moles per request, from a free-running LFSR.
//
// Ports:
//   clk            - system clock
//   reset          - synchronous active-high reset
//   ready_for_mole - FSM request level; a draw runs while it is held high
//   level_select   - level code; 3'b100 lights two distinct moles
//   led_number     - one-hot / two-hot mole mask, held between draws
//   rng_ready      - one-cycle pulse, led_number valid in the same cycle
//   mole_index     - index of the first mole in led_number
//   busy           - high while a draw is in progress
module mole_spawner #(
    parameter int unsigned LED_COUNT = 18,
    parameter logic [15:0] LFSR_SEED = 16'hACE1,
    parameter int unsigned MAX_TRIES = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 ready_for_mole,
    input  logic [2:0]           level_select,
    output logic [LED_COUNT-1:0] led_number,
    output logic                 rng_ready,
    output logic [4:0]           mole_index,
    output logic                 busy
);

    localparam logic [15:0] SEED = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;
    localparam logic [15:0] TAPS = 16'hB400;
    localparam int unsigned TW = $clog2(MAX_TRIES + 2);
    localparam logic [TW-1:0] TRY_LIMIT = TW'(MAX_TRIES);
    localparam logic [4:0] NONE = 5'd31;
    localparam logic [4:0] LAST = 5'(LED_COUNT - 1);
    localparam logic [5:0] NUM = 6'(LED_COUNT);
    localparam logic [2:0] LVL_TWO = 3'b100;

    typedef enum logic [1:0] {
        IDLE,
        DRAW1,
        DRAW2,
        WAIT_DROP
    } state_e;

    state_e               state_q;
    logic [15:0]          lfsr_q;
    logic [15:0]          lfsr_d;
    logic [TW-1:0]        tries_q;
    logic [2:0]           lvl_q;
    logic [4:0]           prev_q;
    logic [4:0]           first_q;
    logic [LED_COUNT-1:0] led_q;
    logic                 rdy_q;
    logic [4:0]           idx_q;

    logic [4:0] cand;
    logic [4:0] excl;
    logic [4:0] fallback;
    logic [4:0] pick;
    logic       at_limit;
    logic       accept;

    function automatic logic [LED_COUNT-1:0] onehot(input logic [4:0] idx);
        return {{(LED_COUNT-1){1'b0}}, 1'b1} << idx;
    endfunction

    // Galois step, right-shifting; a nonzero state never reaches zero.
    always_comb begin
        lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? TAPS : 16'h0000);
    end

    // The first draw avoids the previous mole, the second avoids the first.
    always_comb begin
        cand     = lfsr_q[4:0];
        excl     = (state_q == DRAW2) ? first_q : prev_q;
        at_limit = (tries_q == TRY_LIMIT);
        fallback = 5'd0;
        if (excl != NONE && excl != LAST) begin
            fallback = excl + 5'd1;
        end
        accept = at_limit || (({1'b0, cand} < NUM) && (cand != excl));
        pick   = at_limit ? fallback : cand;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            lfsr_q  <= SEED;
            tries_q <= '0;
            lvl_q   <= '0;
            prev_q  <= NONE;
            first_q <= '0;
            led_q   <= '0;
            rdy_q   <= 1'b0;
            idx_q   <= '0;
        end else begin
            lfsr_q <= lfsr_d;
            rdy_q  <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (ready_for_mole) begin
                        lvl_q   <= level_select;
                        tries_q <= '0;
                        state_q <= DRAW1;
                    end
                end
                DRAW1: begin
                    if (!ready_for_mole) begin
                        state_q <= IDLE;
                    end else if (!accept) begin
                        tries_q <= tries_q + 1'b1;
                    end else if (lvl_q == LVL_TWO) begin
                        first_q <= pick;
                        tries_q <= '0;
                        state_q <= DRAW2;
                    end else begin
                        first_q <= pick;
                        led_q   <= onehot(pick);
                        idx_q   <= pick;
                        prev_q  <= pick;
                        rdy_q   <= 1'b1;
                        state_q <= WAIT_DROP;
                    end
                end
                DRAW2: begin
                    if (!ready_for_mole) begin
                        state_q <= IDLE;
                    end else if (!accept) begin
                        tries_q <= tries_q + 1'b1;
                    end else begin
                        led_q   <= onehot(first_q) | onehot(pick);
                        idx_q   <= first_q;
                        prev_q  <= first_q;
                        rdy_q   <= 1'b1;
                        state_q <= WAIT_DROP;
                    end
                end
                WAIT_DROP: begin
                    if (!ready_for_mole) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign led_number = led_q;
    assign rng_ready  = rdy_q;
    assign mole_index = idx_q;
    assign busy       = (state_q == DRAW1) || (state_q == DRAW2);

endmodule

// File: tb/tb_mole_spawner.sv
// tb_mole_spawner: directed scenarios for mole_spawner, default instance
// plus a MAX_TRIES=0 instance whose draws are fully deterministic.
module tb_mole_spawner;

    localparam int          MAXT = 8;
    localparam logic [15:0] SEED = 16'hACE1;

    logic        clk = 1'b0;
    logic        rst;
    logic        ready_for_mole;
    logic [2:0]  level_select;
    logic [17:0] led_number;
    logic        rng_ready;
    logic [4:0]  mole_index;
    logic        busy;

    logic        rst0;
    logic        ready0;
    logic [2:0]  level0;
    logic [17:0] led0;
    logic        rng0;
    logic [4:0]  idx0;
    logic        busy0;

    int tests = 0;
    int fails = 0;

    logic [15:0] m_lfsr;
    logic [4:0]  m_prev;
    logic [17:0] m_led;

    mole_spawner u_dut (
        .clk(clk), .reset(rst), .ready_for_mole(ready_for_mole),
        .level_select(level_select), .led_number(led_number),
        .rng_ready(rng_ready), .mole_index(mole_index), .busy(busy)
    );

    mole_spawner #(.MAX_TRIES(0)) u_fb (
        .clk(clk), .reset(rst0), .ready_for_mole(ready0),
        .level_select(level0), .led_number(led0),
        .rng_ready(rng0), .mole_index(idx0), .busy(busy0)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] lstep(input logic [15:0] v);
        return {1'b0, v[15:1]} ^ (v[0] ? 16'hB400 : 16'h0000);
    endfunction

    function automatic logic [4:0] fbk(input logic [4:0] ex);
        if (ex == 5'd31 || ex == 5'd17) return 5'd0;
        return ex + 5'd1;
    endfunction

    function automatic logic [17:0] oh(input logic [4:0] i);
        return 18'd1 << i;
    endfunction

    // Reference LFSR, in step with the DUT's register.
    always @(posedge clk) begin
        if (rst) m_lfsr <= SEED;
        else     m_lfsr <= lstep(m_lfsr);
    end

    // One handshake on the default instance with a reference prediction.
    task automatic draw(input logic [2:0] lvl, input logic [2:0] mid,
                        output bit got, output int lat,
                        output logic [17:0] oled, output logic [4:0] oidx,
                        output logic orng2, output logic [17:0] oled2,
                        output int elat, output logic [17:0] eled,
                        output logic [4:0] eidx);
        bit two, mdone, acc;
        int cyc, mt, stage;
        logic [4:0] c, ex, pk, mf, ms;
        two = (lvl == 3'b100);
        mdone = 0; mt = 0; stage = 1; mf = '0; ms = '0;
        got = 0; lat = -1; oled = '0; oidx = '0;
        elat = -1; eled = '0; eidx = '0;
        level_select = lvl;
        ready_for_mole = 1'b1;
        @(negedge clk);
        cyc = 1;
        while (!got && cyc <= 3 + 2 * MAXT + 2) begin
            if (rng_ready === 1'b1) begin
                got = 1; lat = cyc; oled = led_number; oidx = mole_index;
            end else begin
                if (!mdone) begin
                    ex = (stage == 1) ? m_prev : mf;
                    c = m_lfsr[4:0];
                    if (mt == MAXT) begin
                        acc = 1; pk = fbk(ex);
                    end else begin
                        acc = (c < 5'd18) && (c != ex); pk = c;
                    end
                    if (!acc) begin
                        mt++;
                    end else if (stage == 1 && two) begin
                        mf = pk; stage = 2; mt = 0;
                    end else begin
                        if (stage == 1) mf = pk;
                        else ms = pk;
                        mdone = 1; elat = cyc + 1; eidx = mf;
                        eled = oh(mf) | (two ? oh(ms) : 18'd0);
                    end
                end
                if (cyc == 1) level_select = mid;
                @(negedge clk);
                cyc++;
            end
        end
        ready_for_mole = 1'b0;
        @(negedge clk);
        orng2 = rng_ready;
        oled2 = led_number;
        if (mdone) begin
            m_prev = mf;
            m_led = eled;
        end
    endtask

    task automatic fb_draw(input logic [2:0] lvl, output bit got,
                           output int lat, output logic [17:0] oled,
                           output logic [4:0] oidx, output logic orng2);
        int cyc;
        got = 0; lat = -1; oled = '0; oidx = '0;
        level0 = lvl;
        ready0 = 1'b1;
        @(negedge clk);
        cyc = 1;
        while (!got && cyc <= 8) begin
            if (rng0 === 1'b1) begin
                got = 1; lat = cyc; oled = led0; oidx = idx0;
            end else begin
                @(negedge clk);
                cyc++;
            end
        end
        ready0 = 1'b0;
        @(negedge clk);
        orng2 = rng0;
    endtask

    task automatic test_reset();
        bit got; int lat, elat;
        logic [17:0] oled, oled2, eled; logic [4:0] oidx, eidx; logic r2;
        rst = 1'b1; rst0 = 1'b1;
        ready_for_mole = 1'b0; level_select = '0;
        ready0 = 1'b0; level0 = '0;
        repeat (2) @(negedge clk);
        tests++; if (led_number !== 18'd0) begin fails++; $display("FAIL reset_led got %h want 0", led_number); end
        tests++; if (rng_ready !== 1'b0) begin fails++; $display("FAIL reset_rdy got %b want 0", rng_ready); end
        tests++; if (mole_index !== 5'd0) begin fails++; $display("FAIL reset_idx got %0d want 0", mole_index); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b want 0", busy); end
        tests++; if (led0 !== 18'd0 || busy0 !== 1'b0) begin fails++; $display("FAIL reset_fb got %h/%b want 0/0", led0, busy0); end
        m_prev = 5'd31; m_led = '0;
        rst = 1'b0; rst0 = 1'b0;
        draw(3'b001, 3'b001, got, lat, oled, oidx, r2, oled2, elat, eled, eidx);
        tests++; if (!got || lat < 2 || lat > 2 + MAXT) begin fails++; $display("FAIL first_lat got %0d want 2..%0d", lat, 2 + MAXT); end
        tests++; if (lat != elat) begin fails++; $display("FAIL first_lat_exact got %0d want %0d", lat, elat); end
        tests++; if ($countones(oled) != 1) begin fails++; $display("FAIL first_pop got %0d want 1", $countones(oled)); end
        tests++; if (oled !== eled || oidx !== eidx) begin fails++; $display("FAIL first_val got %h/%0d want %h/%0d", oled, oidx, eled, eidx); end
        tests++; if (oidx > 5'd17 || oled[oidx] !== 1'b1) begin fails++; $display("FAIL first_bit got idx %0d mask %h want bit set", oidx, oled); end
        tests++; if (r2 !== 1'b0 || oled2 !== oled) begin fails++; $display("FAIL first_pulse got %b/%h want 0/%h", r2, oled2, oled); end
    endtask

    task automatic test_random();
        bit got; int lat, elat;
        logic [17:0] oled, oled2, eled; logic [4:0] oidx, eidx, last; logic r2;
        logic [2:0] lvl;
        bit hit [18];
        for (int k = 0; k < 18; k++) hit[k] = 0;
        last = m_prev;
        for (int i = 0; i < 1000; i++) begin
            lvl = 3'(i % 8);
            if (lvl == 3'b100) lvl = 3'b000;
            draw(lvl, (i % 2 == 1) ? 3'b100 : lvl, got, lat, oled, oidx, r2, oled2, elat, eled, eidx);
            tests++; if (!got || oidx !== eidx || oled !== eled) begin fails++; $display("FAIL rand_val[%0d] got %h/%0d want %h/%0d", i, oled, oidx, eled, eidx); end
            tests++; if (lat != elat || lat > 2 + MAXT) begin fails++; $display("FAIL rand_lat[%0d] got %0d want %0d", i, lat, elat); end
            tests++; if (oidx == last || oidx > 5'd17) begin fails++; $display("FAIL rand_repeat[%0d] got %0d prev %0d", i, oidx, last); end
            tests++; if (r2 !== 1'b0) begin fails++; $display("FAIL rand_pulse[%0d] got %b want 0", i, r2); end
            if (oidx <= 5'd17) hit[oidx] = 1;
            last = oidx;
        end
        for (int k = 0; k < 18; k++) begin
            tests++; if (!hit[k]) begin fails++; $display("FAIL rand_cover idx %0d got 0 want 1", k); end
        end
    endtask

    task automatic test_two_mole();
        bit got; int lat, elat;
        logic [17:0] oled, oled2, eled; logic [4:0] oidx, eidx, pv; logic r2;
        for (int i = 0; i < 20; i++) begin
            pv = m_prev;
            draw(3'b100, (i % 3 == 0) ? 3'b001 : 3'b100, got, lat, oled, oidx, r2, oled2, elat, eled, eidx);
            tests++; if ($countones(oled) != 2) begin fails++; $display("FAIL two_pop[%0d] got %0d want 2", i, $countones(oled)); end
            tests++; if (!got || oled !== eled || oidx !== eidx) begin fails++; $display("FAIL two_val[%0d] got %h/%0d want %h/%0d", i, oled, oidx, eled, eidx); end
            tests++; if (oidx == pv) begin fails++; $display("FAIL two_repeat[%0d] got %0d prev %0d", i, oidx, pv); end
            tests++; if (lat != elat || lat > 3 + 2 * MAXT) begin fails++; $display("FAIL two_lat[%0d] got %0d want %0d", i, lat, elat); end
            tests++; if (r2 !== 1'b0 || oled2 !== oled) begin fails++; $display("FAIL two_pulse[%0d] got %b want 0", i, r2); end
        end
    endtask

    task automatic test_abort();
        bit got; int lat, elat;
        logic [17:0] oled, oled2, eled; logic [4:0] oidx, eidx; logic r2;
        level_select = 3'b001;
        ready_for_mole = 1'b1;
        @(negedge clk);
        tests++; if (busy !== 1'b1) begin fails++; $display("FAIL abort_busy got %b want 1", busy); end
        ready_for_mole = 1'b0;
        @(negedge clk);
        tests++; if (busy !== 1'b0 || rng_ready !== 1'b0) begin fails++; $display("FAIL abort_idle got %b/%b want 0/0", busy, rng_ready); end
        tests++; if (led_number !== m_led || mole_index !== m_prev) begin fails++; $display("FAIL abort_hold got %h/%0d want %h/%0d", led_number, mole_index, m_led, m_prev); end
        @(negedge clk);
        tests++; if (rng_ready !== 1'b0 || led_number !== m_led) begin fails++; $display("FAIL abort_quiet got %b/%h want 0/%h", rng_ready, led_number, m_led); end
        draw(3'b001, 3'b001, got, lat, oled, oidx, r2, oled2, elat, eled, eidx);
        tests++; if (!got || oled !== eled || oidx !== eidx || lat != elat) begin fails++; $display("FAIL abort_next got %h/%0d/%0d want %h/%0d/%0d", oled, oidx, lat, eled, eidx, elat); end
    endtask

    task automatic test_fallback();
        bit got; int lat; logic [17:0] oled; logic [4:0] oidx, ei; logic r2;
        for (int k = 0; k < 19; k++) begin
            ei = 5'(k % 18);
            fb_draw(3'b001, got, lat, oled, oidx, r2);
            tests++; if (!got || lat != 2) begin fails++; $display("FAIL fb_lat[%0d] got %0d want 2", k, lat); end
            tests++; if (oled !== (18'd1 << ei) || oidx !== ei) begin fails++; $display("FAIL fb_val[%0d] got %h/%0d want %h/%0d", k, oled, oidx, 18'd1 << ei, ei); end
            tests++; if (r2 !== 1'b0) begin fails++; $display("FAIL fb_pulse[%0d] got %b want 0", k, r2); end
        end
        fb_draw(3'b100, got, lat, oled, oidx, r2);
        tests++; if (!got || lat != 3) begin fails++; $display("FAIL fb_two_lat got %0d want 3", lat); end
        tests++; if (oled !== 18'h00006 || oidx !== 5'd1) begin fails++; $display("FAIL fb_two_val got %h/%0d want 00006/1", oled, oidx); end
    endtask

    task automatic test_reset_mid();
        bit got; int lat; logic [17:0] oled; logic [4:0] oidx; logic r2;
        level0 = 3'b100;
        ready0 = 1'b1;
        @(negedge clk);
        tests++; if (busy0 !== 1'b1) begin fails++; $display("FAIL rmid_draw1 got %b want 1", busy0); end
        @(negedge clk);
        tests++; if (busy0 !== 1'b1 || rng0 !== 1'b0) begin fails++; $display("FAIL rmid_draw2 got %b/%b want 1/0", busy0, rng0); end
        rst0 = 1'b1;
        ready0 = 1'b0;
        @(negedge clk);
        tests++; if (led0 !== 18'd0 || idx0 !== 5'd0) begin fails++; $display("FAIL rmid_out got %h/%0d want 0/0", led0, idx0); end
        tests++; if (rng0 !== 1'b0 || busy0 !== 1'b0) begin fails++; $display("FAIL rmid_ctl got %b/%b want 0/0", rng0, busy0); end
        rst0 = 1'b0;
        @(negedge clk);
        fb_draw(3'b001, got, lat, oled, oidx, r2);
        tests++; if (!got || lat != 2 || oled !== 18'h00001 || oidx !== 5'd0) begin fails++; $display("FAIL rmid_prev got %h/%0d/%0d want 00001/0/2", oled, oidx, lat); end
    endtask

    initial begin
        test_reset();
        test_random();
        test_two_mole();
        test_abort();
        test_fallback();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
